scancode_tx: RTL and testbench
==============================

Name: scancode_tx

Overview:
Key-event to PS/2 Set-2 scan-code byte serializer, the transmit-side counterpart of the keyboard byte receiver. It accepts make/break events carrying a 9-bit key code ({ext, code[7:0]}) and buffers them in a small FIFO. Each event is emitted as the byte sequence [E0] [F0] code over a valid/ready byte interface, with a programmable idle gap between bytes. It feeds a PS/2 line driver, or a keyboard-emulation loopback into the receiver path.

Parameters:
DEPTH, 4, event FIFO depth in entries; power of 2, minimum 2.
GAP_CYCLES, 2, idle clocks forced after each accepted byte before the next byte is presented; 0 = back-to-back.

Ports:
clk  in  1  system clock; all logic on rising edge.
resetN  in  1  asynchronous active-low reset.
key_code  in  9  {ext, code[7:0]}; sampled only when make or brakk is high.
make  in  1  one-cycle strobe: key-press event.
brakk  in  1  one-cycle strobe: key-release event.
dout  out  8  byte presented to the downstream line driver.
dout_valid  out  1  dout holds a valid byte.
dout_ready  in  1  downstream accepts; a transfer occurs at a rising edge where dout_valid=1 and dout_ready=1.
busy  out  1  1 when the FSM is not IDLE or the FIFO is non-empty.
overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by reset.
bad_code  out  1  one-cycle pulse when an event is rejected for an invalid code.

Behaviour:
- Reset (async, resetN=0): dout=8'h00, dout_valid=0, busy=0, overflow=0, bad_code=0. FIFO is emptied, FSM goes to IDLE, gap counter clears. Any byte in flight is abandoned and is not resumed.
- Event capture (every clock):
  - event = make | brakk. If both are high, make wins (is_break=0).
  - Valid code: code[7:0] in 1..131 (8'h01..8'h83).
  - Invalid code: event dropped, bad_code=1 on the next cycle. FIFO is not written and overflow is unaffected.
  - Valid code with FIFO full: event dropped, overflow set. Full is evaluated before any same-cycle pop, so a simultaneous pop does not make room.
  - Otherwise push {is_break, ext, code} into the FIFO.
- FIFO: DEPTH entries, read/write pointers with wrap-around, separate count or extra pointer bit for full/empty. Strict event order is preserved.
- FSM states and transitions: IDLE, LOAD, SEND_EXT, SEND_REL, SEND_CODE, GAP.
  - IDLE: FIFO non-empty -> pop the head into the event register, go to LOAD.
  - LOAD: ext=1 -> SEND_EXT; else if is_break -> SEND_REL; else -> SEND_CODE.
  - SEND_EXT: dout=8'hE0, dout_valid=1. On transfer -> GAP, then next = SEND_REL if is_break, else SEND_CODE.
  - SEND_REL: dout=8'hF0, dout_valid=1. On transfer -> GAP, then next = SEND_CODE.
  - SEND_CODE: dout=code, dout_valid=1. On transfer -> GAP, then next = IDLE.
  - GAP: dout_valid=0 for exactly GAP_CYCLES clocks, then go to the recorded next state. With GAP_CYCLES=0, the GAP state is skipped and the next state follows directly after the transfer.
  - Illegal state encoding -> IDLE.
- Handshake:
  - dout and dout_valid are registered outputs.
  - Once dout_valid rises, dout is held stable and dout_valid stays high until a transfer occurs.
  - dout_valid never drops without a transfer, except on reset.
- Latency: event sampled at edge T with the FSM in IDLE and the FIFO empty -> pop at edge T+1 -> first byte valid at edge T+3, after the LOAD cycle.
- Byte sequences:
  - make, ext=0: code
  - brakk, ext=0: F0 code
  - make, ext=1: E0 code
  - brakk, ext=1: E0 F0 code
- busy is combinational from the FSM state and FIFO-empty; it is 0 only when both are idle.
- Events keep being accepted into the FIFO while the FSM is sending.

Test Plan:
- GAP_CYCLES=2, dout_ready=1; make with key_code=9'h01C -> single transfer 8'h1C, dout_valid high 1 cycle, then 2 idle cycles; busy returns to 0 afterwards.
- brakk with 9'h01C -> transfers 8'hF0, then 8'h1C, with exactly 2 idle cycles between them.
- make with 9'h175 -> transfers E0, 75. brakk with 9'h175 -> transfers E0, F0, 75, in order, with a gap after each byte.
- Backpressure: hold dout_ready=0 for 5 cycles while F0 is presented -> dout stays 8'hF0 and dout_valid stays 1 for all 5 cycles; raise dout_ready -> F0 transfers once, then 1C follows.
- Overflow, DEPTH=4: dout_ready=0, six consecutive make strobes with codes 01..06 -> sixth is dropped and overflow=1. Release dout_ready -> exactly bytes 01,02,03,04,05 appear, in order.
- Reject and reset cases:
  - make with 9'h000 or 9'h0F0 -> bad_code pulse and no bytes emitted.
  - make and brakk both high with 9'h01C -> only 1C emitted, no F0.
  - resetN=0 in the middle of E0 F0 75 -> all outputs return to reset values and no further bytes are emitted.

Source files
------------

// File: rtl/scancode_tx_if.sv
// Byte-stream link between the scan-code serializer and its consumer.
//   dout       : byte presented by the master
//   dout_valid : dout holds a valid byte
//   dout_ready : consumer accepts; transfer on a rising edge with valid & ready
interface scancode_tx_if;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;

    modport master (
        output dout,
        output dout_valid,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        output dout_ready
    );
endinterface

// File: rtl/scancode_tx.sv
// Key-event to PS/2 Set-2 scan-code byte serializer.
// Make/break events are buffered in a small FIFO and each one is emitted
// as [E0] [F0] code over a valid/ready byte link, with an idle gap after
// every accepted byte.
//   clk, resetN : clock, asynchronous active-low reset
//   key_code    : {ext, code[7:0]}, sampled when make or brakk is high
//   make, brakk : one-cycle key-press / key-release strobes (make wins)
//   bus         : master side of the byte link (dout, dout_valid, dout_ready)
//   busy        : FSM not idle or FIFO non-empty (combinational)
//   overflow    : sticky, an event was dropped on a full FIFO
//   bad_code    : one-cycle pulse, an event was rejected for an invalid code
module scancode_tx #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic [8:0]           key_code,
    input  logic                 make,
    input  logic                 brakk,
    scancode_tx_if.master        bus,
    output logic                 busy,
    output logic                 overflow,
    output logic                 bad_code
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES == 0) ? '0 : GW'(GAP_CYCLES - 1);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_REL = 8'hF0;
    localparam logic [7:0] CODE_MAX = 8'h83;

    typedef struct packed {
        logic       is_break;
        logic       ext;
        logic [7:0] code;
    } key_ev_t;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_SEND_EXT  = 3'd2,
        S_SEND_REL  = 3'd3,
        S_SEND_CODE = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Event capture
    // ------------------------------------------------------------------
    logic    ev_strobe;
    logic    code_ok;
    logic    fifo_full;
    logic    fifo_empty;
    logic    push;
    logic    pop;
    key_ev_t in_ev;

    assign ev_strobe = make | brakk;
    assign code_ok   = (key_code[7:0] != 8'h00) && (key_code[7:0] <= CODE_MAX);
    assign push      = ev_strobe & code_ok & ~fifo_full;

    // make has priority when both strobes are high
    assign in_ev.is_break = ~make;
    assign in_ev.ext      = key_code[8];
    assign in_ev.code     = key_code[7:0];

    // ------------------------------------------------------------------
    // Event FIFO
    // ------------------------------------------------------------------
    key_ev_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);

    // Storage array, written only on accepted events
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_ev;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // Status flags: full is judged before any same-cycle pop
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            overflow <= overflow | (ev_strobe & code_ok & fifo_full);
            bad_code <= ev_strobe & ~code_ok;
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    state_t        after_q;
    state_t        after_d;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    key_ev_t       ev_q;
    key_ev_t       ev_d;
    logic [7:0]    dout_q;
    logic [7:0]    dout_d;
    logic          valid_q;
    logic          valid_d;
    logic          xfer;
    logic          advance;
    state_t        target;

    assign xfer = valid_q & bus.dout_ready;

    // State, event and registered byte-link outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            after_q <= S_IDLE;
            gap_q   <= '0;
            ev_q    <= '0;
            dout_q  <= 8'h00;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            after_q <= after_d;
            gap_q   <= gap_d;
            ev_q    <= ev_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
        end
    end

    // Next state, FIFO pop, and output values derived from the next state
    always_comb begin
        state_d = state_q;
        after_d = after_q;
        gap_d   = gap_q;
        ev_d    = ev_q;
        pop     = 1'b0;
        advance = 1'b0;
        target  = S_IDLE;
        dout_d  = dout_q;
        valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    ev_d    = mem[rd_ptr_q];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (ev_q.ext) begin
                    state_d = S_SEND_EXT;
                end else if (ev_q.is_break) begin
                    state_d = S_SEND_REL;
                end else begin
                    state_d = S_SEND_CODE;
                end
            end
            S_SEND_EXT: begin
                if (xfer) begin
                    advance = 1'b1;
                    target  = ev_q.is_break ? S_SEND_REL : S_SEND_CODE;
                end
            end
            S_SEND_REL: begin
                if (xfer) begin
                    advance = 1'b1;
                    target  = S_SEND_CODE;
                end
            end
            S_SEND_CODE: begin
                if (xfer) begin
                    advance = 1'b1;
                    target  = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = after_q;
                end else begin
                    gap_d = gap_q - GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // After a transfer either idle for the gap or go straight on
        if (advance) begin
            if (GAP_CYCLES == 0) begin
                state_d = target;
            end else begin
                state_d = S_GAP;
                after_d = target;
                gap_d   = GAP_LOAD;
            end
        end

        // Byte shown follows the state being entered, so it stays put while held
        case (state_d)
            S_SEND_EXT: begin
                dout_d  = BYTE_EXT;
                valid_d = 1'b1;
            end
            S_SEND_REL: begin
                dout_d  = BYTE_REL;
                valid_d = 1'b1;
            end
            S_SEND_CODE: begin
                dout_d  = ev_q.code;
                valid_d = 1'b1;
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign busy           = (state_q != S_IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_scancode_tx.sv
// Self-checking bench for scancode_tx: a scoreboard queue of expected bytes
// is filled when events are driven and drained by a byte-link monitor.
module tb_scancode_tx;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned GAP   = 2;

    logic       clk;
    logic       resetN;
    logic [8:0] key_code;
    logic       make;
    logic       brakk;
    logic       busy;
    logic       overflow;
    logic       bad_code;

    scancode_tx_if bus ();

    scancode_tx #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk      (clk),
        .resetN   (resetN),
        .key_code (key_code),
        .make     (make),
        .brakk    (brakk),
        .bus      (bus),
        .busy     (busy),
        .overflow (overflow),
        .bad_code (bad_code)
    );

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         n_xfer = 0;
    int         strobe_cyc = 0;
    logic [7:0] exp_q [$];
    int         xcyc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Inputs are stable from posedge+1 to the next posedge, so a negedge
    // sample of valid & ready sees exactly the transfers of the next edge.
    always @(negedge clk) begin
        if (resetN && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
            n_xfer++;
            xcyc.push_back(cyc + 1);
            chk("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                chk("byte_value", 32'(bus.dout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [8:0] kc, input logic mk, input logic br);
        key_code   = kc;
        make       = mk;
        brakk      = br;
        strobe_cyc = cyc;
        step();
        make  = 1'b0;
        brakk = 1'b0;
    endtask

    task automatic wait_xfer(input int target, input int max_cyc);
        int k = 0;
        while (n_xfer < target && k < max_cyc) begin
            step();
            k++;
        end
        chk("xfer_wait", 32'(n_xfer >= target), 32'd1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && k < max_cyc) begin
            step();
            k++;
        end
        chk("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic check_gaps(input int first, input string tag);
        for (int i = first + 1; i < xcyc.size(); i++) begin
            chk(tag, 32'(xcyc[i] - xcyc[i-1]), 32'(GAP + 1));
        end
    endtask

    initial begin
        int base;
        int i0;

        resetN         = 1'b0;
        key_code       = 9'h000;
        make           = 1'b0;
        brakk          = 1'b0;
        bus.dout_ready = 1'b1;
        repeat (3) step();

        chk("rst_dout", 32'(bus.dout), 32'h00);
        chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_bad_code", 32'(bad_code), 32'd0);
        resetN = 1'b1;
        repeat (2) step();

        // Plain make: one byte, latency, then an idle gap
        base = n_xfer;
        i0   = xcyc.size();
        exp_q.push_back(8'h1C);
        strobe(9'h01C, 1'b1, 1'b0);
        wait_xfer(base + 1, 20);
        if (xcyc.size() > i0) chk("latency", 32'(xcyc[i0] - (strobe_cyc + 1)), 32'd3);
        @(negedge clk);
        chk("gap_valid_1", 32'(bus.dout_valid), 32'd0);
        @(negedge clk);
        chk("gap_valid_2", 32'(bus.dout_valid), 32'd0);
        wait_idle(30);
        chk("make_count", 32'(n_xfer - base), 32'd1);

        // Plain break: F0 1C
        base = n_xfer;
        i0   = xcyc.size();
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        strobe(9'h01C, 1'b0, 1'b1);
        wait_idle(40);
        chk("brk_count", 32'(n_xfer - base), 32'd2);
        check_gaps(i0, "brk_gap");

        // Extended make: E0 75
        base = n_xfer;
        i0   = xcyc.size();
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'h75);
        strobe(9'h175, 1'b1, 1'b0);
        wait_idle(40);
        chk("ext_make_count", 32'(n_xfer - base), 32'd2);
        check_gaps(i0, "ext_make_gap");

        // Extended break: E0 F0 75
        base = n_xfer;
        i0   = xcyc.size();
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h75);
        strobe(9'h175, 1'b0, 1'b1);
        wait_idle(50);
        chk("ext_brk_count", 32'(n_xfer - base), 32'd3);
        check_gaps(i0, "ext_brk_gap");

        // Invalid codes: bad_code pulse, nothing emitted; 83 is the last valid code
        base = n_xfer;
        strobe(9'h000, 1'b1, 1'b0);
        chk("bad_000_pulse", 32'(bad_code), 32'd1);
        step();
        chk("bad_000_clear", 32'(bad_code), 32'd0);
        strobe(9'h0F0, 1'b1, 1'b0);
        chk("bad_0F0_pulse", 32'(bad_code), 32'd1);
        strobe(9'h084, 1'b1, 1'b0);
        chk("bad_084_pulse", 32'(bad_code), 32'd1);
        repeat (12) step();
        chk("bad_no_bytes", 32'(n_xfer - base), 32'd0);
        chk("bad_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'h83);
        strobe(9'h083, 1'b1, 1'b0);
        chk("ok_083_no_pulse", 32'(bad_code), 32'd0);
        wait_idle(30);
        chk("ok_083_count", 32'(n_xfer - base), 32'd1);

        // make and brakk together: make wins, no F0
        base = n_xfer;
        exp_q.push_back(8'h1C);
        strobe(9'h01C, 1'b1, 1'b1);
        wait_idle(30);
        chk("both_count", 32'(n_xfer - base), 32'd1);

        // Backpressure on F0: byte held stable until accepted
        base = n_xfer;
        bus.dout_ready = 1'b0;
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h1C);
        strobe(9'h01C, 1'b0, 1'b1);
        for (int k = 0; k < 20 && bus.dout_valid !== 1'b1; k++) step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold_dout", 32'(bus.dout), 32'hF0);
            chk("hold_valid", 32'(bus.dout_valid), 32'd1);
        end
        step();
        bus.dout_ready = 1'b1;
        wait_idle(40);
        chk("hold_count", 32'(n_xfer - base), 32'd2);

        // Overflow: sixth back-to-back event dropped, first five kept in order
        base = n_xfer;
        bus.dout_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k <= 5) exp_q.push_back(8'(k));
            strobe(9'(k), 1'b1, 1'b0);
            if (k == 5) chk("ovf_before", 32'(overflow), 32'd0);
        end
        chk("ovf_set", 32'(overflow), 32'd1);
        repeat (3) step();
        bus.dout_ready = 1'b1;
        wait_idle(200);
        chk("ovf_count", 32'(n_xfer - base), 32'd5);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Reset in the middle of E0 F0 75
        base = n_xfer;
        exp_q.push_back(8'hE0);
        exp_q.push_back(8'hF0);
        exp_q.push_back(8'h75);
        strobe(9'h175, 1'b0, 1'b1);
        wait_xfer(base + 1, 20);
        exp_q.delete();
        resetN = 1'b0;
        #1;
        chk("mid_rst_dout", 32'(bus.dout), 32'h00);
        chk("mid_rst_valid", 32'(bus.dout_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_overflow", 32'(overflow), 32'd0);
        chk("mid_rst_bad_code", 32'(bad_code), 32'd0);
        repeat (3) step();
        resetN = 1'b1;
        repeat (20) step();
        chk("mid_rst_no_bytes", 32'(n_xfer - base), 32'd1);
        chk("mid_rst_idle", 32'(busy), 32'd0);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
